// File: rtl/alu_issuer_pkg.sv
// Shared types and widths for the ALU command issuer and its command FIFO.
package alu_issuer_pkg;

    localparam int OPND_W = 4;
    localparam int SEL_W  = 3;
    localparam int RES_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [SEL_W-1:0]  sel;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of ALU commands; head entry is visible on dout
// whenever the FIFO is non-empty.
module alu_cmd_fifo
    import alu_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  alu_cmd_t               din,
    output alu_cmd_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    alu_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives them onto the ALU one at a time, and returns the
// captured results in order on a valid/ready response stream.
module alu_cmd_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [RES_W-1:0]  alu_y,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_y,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic [SEL_W-1:0]  rsp_sel,
    output logic [CNT_W-1:0]  op_count,
    output logic              busy
);

    // Both streams: a transfer happens at a rising edge where valid && ready;
    // the source holds its payload stable while valid && !ready.

    state_t                 state;
    alu_cmd_t               fifo_din;
    alu_cmd_t               fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   push;
    logic                   pop;
    logic                   rsp_hs;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign fifo_din  = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign pop       = !fifo_empty && ((state == IDLE) || (state == RESP && rsp_hs));
    assign busy      = (state != IDLE) || (fifo_count != '0);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_sel   <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a   <= fifo_head.a;
                        alu_b   <= fifo_head.b;
                        alu_sel <= fifo_head.sel;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    // ALU inputs have been stable for a full cycle here.
                    rsp_y     <= alu_y;
                    rsp_carry <= alu_carry;
                    rsp_zero  <= alu_zero;
                    rsp_sel   <= alu_sel;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        op_count  <= op_count + 1'b1;
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_a   <= fifo_head.a;
                            alu_b   <= fifo_head.b;
                            alu_sel <= fifo_head.sel;
                            state   <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Master-side counterpart of the combinational 4-bit-operand ALU core (A[3:0], B[3:0], sel[2:0] in; Y[7:0], carry, zero out).
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Drives each command onto the ALU input port, captures the ALU outputs, and returns them in order on a valid/ready response stream with an operation counter.
- Sits between a host or command front-end and the ALU core inside the tt_um top.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept (count < DEPTH).
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- cmd_sel  input  3  ALU selector.
- alu_a  output  4  registered operand A to the ALU.
- alu_b  output  4  registered operand B to the ALU.
- alu_sel  output  3  registered selector to the ALU.
- alu_y  input  8  ALU result.
- alu_carry  input  1  ALU carry flag.
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts the response.
- rsp_y  output  8  captured result.
- rsp_carry  output  1  captured carry.
- rsp_zero  output  1  captured zero.
- rsp_sel  output  3  selector echo of the completed op.
- op_count  output  CNT_W  completed responses, modulo 2^CNT_W.
- busy  output  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset (rst=1 at a clk edge): FIFO emptied; FSM set to IDLE; every output register cleared to 0 (alu_a, alu_b, alu_sel, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_sel, op_count). After reset, cmd_ready=1 and busy=0.
- Reset mid-operation: any pending response and all queued commands are discarded with no handshake.
- Push: at an edge with cmd_valid && cmd_ready, {a, b, sel} is written at the tail.
  - cmd_ready is a function of the registered count only; no combinational path from rsp_ready or from a pop.
  - Push while full is impossible, because cmd_ready=0.
- FSM states IDLE, DRIVE, RESP:
  - IDLE: if count≠0, pop the head into alu_a/alu_b/alu_sel and go to DRIVE. A command pushed in the same cycle is not bypassed; it is popped on the following edge.
  - DRIVE: the ALU settles for one full cycle. At the next edge, capture alu_y/alu_carry/alu_zero into rsp_y/rsp_carry/rsp_zero, copy alu_sel into rsp_sel, set rsp_valid=1, and go to RESP.
  - RESP: rsp_* held stable while rsp_valid && !rsp_ready. At a handshake edge:
    - op_count increments (wraps to 0);
    - if count≠0, pop the next command, clear rsp_valid, and go to DRIVE;
    - otherwise clear rsp_valid and go to IDLE.
- Latency: a command accepted into an empty FIFO while IDLE shows rsp_valid=1 exactly 2 cycles after the accept edge.
- Sustained throughput is one op per 2 cycles.
- alu_a/alu_b/alu_sel retain the last issued command between operations.
- Simultaneous push and pop: count is unchanged and both take effect.
- Responses are returned strictly in acceptance order.
- Capacity: with the response stalled, DEPTH queued commands plus one issued command are outstanding.

Decomposition:
- Package alu_issuer_pkg contains:
  - state enum {IDLE, DRIVE, RESP};
  - packed struct alu_cmd_t {a[3:0], b[3:0], sel[2:0]};
  - constants OPND_W=4, SEL_W=3, RES_W=8.
- Sub-module alu_cmd_fifo holds the DEPTH-entry synchronous FIFO of alu_cmd_t, with push/pop/full/empty/count ports.
- The FSM and response registers live in the top module.

Test Plan:
- Bench ALU stub: Y=A+B zero-extended, carry=Y[4], zero=(Y==0).
- Reset: hold rst 2 cycles -> all outputs 0, cmd_ready=1, busy=0.
- Single op: a=3, b=5, sel=0, rsp_ready=1 -> rsp_valid=1 two cycles after accept; rsp_y=8, carry=0, zero=0, rsp_sel=0; op_count=1 after the handshake.
- Backpressure: rsp_ready=0, offer 7 back-to-back commands a=1..7, b=1 -> exactly 5 accepted, then cmd_ready=0 and the first response is held stable. Then raise rsp_ready -> rsp_y=2,3,4,5,6 in order and op_count=5.
- Flag capture: stub overridden to alu_y=0, carry=1, zero=1 -> rsp_y=0, rsp_carry=1, rsp_zero=1.
- Reset mid-operation: rsp_valid=1 with 3 commands queued, pulse rst for 1 cycle -> rsp_valid=0, busy=0, op_count=0, and no response for 10 cycles.
- Counter wrap: 256 single-op handshakes -> op_count returns to 0.
